// File: rtl/axis_sync_fifo.sv
// Single-clock AXI4-Stream FIFO: DEPTH-entry RAM followed by a registered
// output stage. The beat held in the output stage is included in count.
// Optional frame mode holds output until a tlast-terminated frame is stored.
// If the FIFO fills with no tlast in it, frame mode releases the head beats
// so the producer cannot deadlock.
module axis_sync_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8) ? 1 : 0,
    parameter int KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
    parameter int USER_WIDTH  = 1,
    parameter int DEPTH       = 16,
    parameter int FRAME_FIFO  = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]        s_axis_tkeep,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic                         s_axis_tlast,
    input  logic [USER_WIDTH-1:0]        s_axis_tuser,
    output logic [DATA_WIDTH-1:0]        m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]        m_axis_tkeep,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    output logic [USER_WIDTH-1:0]        m_axis_tuser,
    output logic [$clog2(DEPTH):0]       count,
    output logic [$clog2(DEPTH):0]       frame_count,
    output logic                         force_release
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [USER_WIDTH-1:0] user_mem [DEPTH];
    logic                  last_mem [DEPTH];

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_next;
    logic [CW-1:0]         frame_q;
    logic [CW-1:0]         frame_next;
    logic [CW-1:0]         ram_cnt;
    logic                  s_ready_q;
    logic                  m_valid_q;
    logic                  m_last_q;
    logic [DATA_WIDTH-1:0] m_data_q;
    logic [USER_WIDTH-1:0] m_user_q;
    logic                  release_q;
    logic                  force_q;
    logic                  frame_seen_q;
    logic                  accept;
    logic                  deliver;
    logic                  acc_last;
    logic                  dlv_last;
    logic                  gate_open;
    logic                  load;

    assign accept   = s_axis_tvalid && s_ready_q;
    assign deliver  = m_valid_q && m_axis_tready;
    assign acc_last = accept && s_axis_tlast;
    assign dlv_last = deliver && m_last_q;
    assign ram_cnt  = count_q - CW'(m_valid_q);

    // frame_seen_q delays the gate by one cycle so a frame's first beat
    // appears two edges after its tlast beat is accepted.
    assign gate_open = (FRAME_FIFO == 0) || release_q || ((frame_q != '0) && frame_seen_q);
    assign load      = (ram_cnt != '0) && (!m_valid_q || m_axis_tready) && gate_open;

    // Next occupancy and next stored-frame count from this cycle's handshakes.
    always_comb begin
        count_next = count_q;
        frame_next = frame_q;
        case ({accept, deliver})
            2'b10:   count_next = count_q + 1'b1;
            2'b01:   count_next = count_q - 1'b1;
            default: count_next = count_q;
        endcase
        case ({acc_last, dlv_last})
            2'b10:   frame_next = frame_q + 1'b1;
            2'b01:   frame_next = frame_q - 1'b1;
            default: frame_next = frame_q;
        endcase
    end

    // Storage write; contents are don't-care until the pointers reach them.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_mem[wr_ptr] <= s_axis_tdata;
            user_mem[wr_ptr] <= s_axis_tuser;
            last_mem[wr_ptr] <= s_axis_tlast;
        end
    end

    // Pointers, counters and the registered input ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count_q      <= '0;
            frame_q      <= '0;
            s_ready_q    <= 1'b0;
            frame_seen_q <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q      <= count_next;
            frame_q      <= frame_next;
            s_ready_q    <= (count_next != FULL);
            frame_seen_q <= (frame_q != '0);
        end
    end

    // Output stage: refill whenever it is empty or being drained this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_user_q  <= '0;
            m_last_q  <= 1'b0;
        end else if (load) begin
            m_valid_q <= 1'b1;
            m_data_q  <= data_mem[rd_ptr];
            m_user_q  <= user_mem[rd_ptr];
            m_last_q  <= last_mem[rd_ptr];
        end else if (deliver) begin
            m_valid_q <= 1'b0;
        end
    end

    // Deadlock release: full with no complete frame opens the gate until a
    // tlast beat leaves.
    always_ff @(posedge clk) begin
        if (rst || (FRAME_FIFO == 0)) begin
            release_q <= 1'b0;
            force_q   <= 1'b0;
        end else begin
            force_q <= 1'b0;
            if (!release_q && (count_q == FULL) && (frame_q == '0)) begin
                release_q <= 1'b1;
                force_q   <= 1'b1;
            end else if (dlv_last) begin
                release_q <= 1'b0;
            end
        end
    end

    generate
        if (KEEP_ENABLE != 0) begin : g_keep
            logic [KEEP_WIDTH-1:0] keep_mem [DEPTH];
            logic [KEEP_WIDTH-1:0] keep_q;

            // Byte-enable storage, written alongside the data.
            always_ff @(posedge clk) begin
                if (accept) begin
                    keep_mem[wr_ptr] <= s_axis_tkeep;
                end
            end

            // Byte-enable output register, loaded with the rest of the beat.
            always_ff @(posedge clk) begin
                if (rst) begin
                    keep_q <= '0;
                end else if (load) begin
                    keep_q <= keep_mem[rd_ptr];
                end
            end

            assign m_axis_tkeep = keep_q;
        end else begin : g_no_keep
            logic unused_keep;
            assign unused_keep  = ^s_axis_tkeep;
            assign m_axis_tkeep = '1;
        end
    endgenerate

    assign s_axis_tready = s_ready_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tuser  = m_user_q;
    assign m_axis_tlast  = m_last_q;
    assign count         = count_q;
    assign frame_count   = frame_q;
    assign force_release = force_q;

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Directed bench for axis_sync_fifo: one streaming instance and one
// frame-mode instance share the stimulus; sel picks which one is active.
module tb_axis_sync_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic       sel = 1'b0;
    logic [7:0] s_data = '0;
    logic [0:0] s_keep = 1'b1;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic [0:0] s_user = '0;
    logic       m_ready = 1'b0;

    logic       a_s_valid, b_s_valid;
    logic       a_s_ready, b_s_ready;
    logic [7:0] a_m_data, b_m_data;
    logic [0:0] a_m_keep, b_m_keep;
    logic       a_m_valid, b_m_valid;
    logic       a_m_last, b_m_last;
    logic [0:0] a_m_user, b_m_user;
    logic [4:0] a_count, b_count;
    logic [4:0] a_frame, b_frame;
    logic       a_force, b_force;

    assign a_s_valid = s_valid & ~sel;
    assign b_s_valid = s_valid & sel;

    logic       s_ready, m_valid, m_last, force_rel;
    logic [7:0] m_data;
    logic [0:0] m_keep, m_user;
    logic [4:0] count, frame_count;

    assign s_ready     = sel ? b_s_ready : a_s_ready;
    assign m_valid     = sel ? b_m_valid : a_m_valid;
    assign m_last      = sel ? b_m_last  : a_m_last;
    assign m_data      = sel ? b_m_data  : a_m_data;
    assign m_keep      = sel ? b_m_keep  : a_m_keep;
    assign m_user      = sel ? b_m_user  : a_m_user;
    assign count       = sel ? b_count   : a_count;
    assign frame_count = sel ? b_frame   : a_frame;
    assign force_rel   = sel ? b_force   : a_force;

    axis_sync_fifo #(.DATA_WIDTH(8), .DEPTH(16), .FRAME_FIFO(0)) u_fifo (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tvalid(a_s_valid),
        .s_axis_tready(a_s_ready), .s_axis_tlast(s_last), .s_axis_tuser(s_user),
        .m_axis_tdata(a_m_data), .m_axis_tkeep(a_m_keep), .m_axis_tvalid(a_m_valid),
        .m_axis_tready(m_ready), .m_axis_tlast(a_m_last), .m_axis_tuser(a_m_user),
        .count(a_count), .frame_count(a_frame), .force_release(a_force)
    );

    axis_sync_fifo #(.DATA_WIDTH(8), .DEPTH(16), .FRAME_FIFO(1)) u_fifo_frame (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tvalid(b_s_valid),
        .s_axis_tready(b_s_ready), .s_axis_tlast(s_last), .s_axis_tuser(s_user),
        .m_axis_tdata(b_m_data), .m_axis_tkeep(b_m_keep), .m_axis_tvalid(b_m_valid),
        .m_axis_tready(m_ready), .m_axis_tlast(b_m_last), .m_axis_tuser(b_m_user),
        .count(b_count), .frame_count(b_frame), .force_release(b_force)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Monitor: handshakes are decided by values stable at the falling edge.
    int n_acc, n_dlv, n_force;
    int first_acc_c, last_acc_c, first_val_c, first_dlv_c, last_dlv_c, fr_at_last;
    logic [9:0] got_q [$];

    task automatic clear_mon();
        n_acc = 0; n_dlv = 0; n_force = 0;
        first_acc_c = -1; last_acc_c = -1; first_val_c = -1;
        first_dlv_c = -1; last_dlv_c = -1; fr_at_last = -1;
        got_q.delete();
    endtask

    always @(negedge clk) begin
        if (!rst && s_valid && s_ready) begin
            if (n_acc == 0) first_acc_c = cyc;
            if (s_last) last_acc_c = cyc;
            n_acc++;
        end
        if (m_valid && first_val_c < 0) first_val_c = cyc;
        if (!rst && m_valid && m_ready) begin
            if (n_dlv == 0) first_dlv_c = cyc;
            last_dlv_c = cyc;
            got_q.push_back({m_user, m_last, m_data});
            if (m_last) fr_at_last = int'(frame_count);
            n_dlv++;
        end
        if (force_rel) n_force++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents n beats base..base+n-1 (tlast on index last_idx), one try per cycle.
    task automatic send(input int n, input int base, input int last_idx);
        int i = 0;
        int guard = 0;
        logic ok;
        while (i < n && guard < 2000) begin
            s_valid = 1'b1;
            s_data  = 8'(base + i);
            s_user  = 1'(base + i);
            s_last  = (i == last_idx);
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
            if (ok) i++;
            guard++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (i < n) chk("send_timeout", i, n);
    endtask

    task automatic wait_dlv(input int n, input int budget);
        for (int i = 0; i < budget && n_dlv < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic check_seq(input string tag, input int base, input int n, input int last_idx);
        int bad = 0;
        logic [7:0] d;
        logic [9:0] e;
        chk({tag, "_len"}, got_q.size(), n);
        for (int i = 0; i < got_q.size() && i < n; i++) begin
            d = 8'(base + i);
            e = {d[0], (i == last_idx), d};
            if (got_q[i] !== e) bad++;
        end
        chk({tag, "_order"}, bad, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int a0, d0, cmin, cmax, nf;

    initial begin
        clear_mon();
        // Reset state
        step(3);
        rst = 1'b0;
        step(1);
        @(negedge clk); #1;
        chk("rst_s_ready", int'(s_ready), 1);
        chk("rst_count", int'(count), 0);
        chk("rst_frame", int'(frame_count), 0);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_data", int'(m_data), 0);
        chk("rst_m_last", int'(m_last), 0);
        chk("rst_m_user", int'(m_user), 0);
        chk("rst_force", int'(force_rel), 0);
        chk("rst_m_keep", int'(m_keep), 1);

        // 1: 20 beats straight through
        step(1);
        clear_mon();
        m_ready = 1'b1;
        send(20, 0, 19);
        wait_dlv(20, 50);
        @(negedge clk); #1;
        chk("t1_latency", first_val_c - first_acc_c, 2);
        chk("t1_contiguous", last_dlv_c - first_dlv_c, 19);
        check_seq("t1", 0, 20, 19);

        // 2: overfill with output stalled, then drain
        step(1);
        clear_mon();
        m_ready = 1'b0;
        fork
            send(20, 0, 19);
        join_none
        step(30);
        @(negedge clk); #1;
        chk("t2_accepted", n_acc, 16);
        chk("t2_s_ready", int'(s_ready), 0);
        chk("t2_count", int'(count), 16);
        chk("t2_head", int'(m_data), 0);
        step(1);
        m_ready = 1'b1;
        wait fork;
        wait_dlv(20, 60);
        check_seq("t2", 0, 20, 19);
        chk("t2_total_acc", n_acc, 20);

        // 3: full FIFO with both sides active for 50 cycles
        step(2);
        clear_mon();
        m_ready = 1'b0;
        send(16, 100, -1);
        @(negedge clk); #1;
        chk("t3_fill", int'(count), 16);
        step(1);
        a0 = n_acc;
        d0 = n_dlv;
        cmin = 99;
        cmax = 0;
        m_ready = 1'b1;
        fork
            send(50, 116, -1);
        join_none
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (int'(count) < cmin) cmin = int'(count);
            if (int'(count) > cmax) cmax = int'(count);
        end
        #1;
        chk("t3_dlv_rate", n_dlv - d0, 50);
        chk("t3_acc_rate", n_acc - a0, 49);
        chk("t3_count_max", cmax, 16);
        chk("t3_count_min", cmin, 15);
        wait fork;
        wait_dlv(66, 100);
        check_seq("t3", 100, 66, -1);

        // 6: reset in the middle of a frame
        step(2);
        clear_mon();
        m_ready = 1'b0;
        send(7, 30, -1);
        @(negedge clk); #1;
        chk("t6_pre_count", int'(count), 7);
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("t6_count", int'(count), 0);
        chk("t6_frame", int'(frame_count), 0);
        chk("t6_m_valid", int'(m_valid), 0);
        step(1);
        clear_mon();
        m_ready = 1'b1;
        send(3, 50, 2);
        wait_dlv(3, 30);
        step(5);
        check_seq("t6", 50, 3, 2);
        chk("t6_frame_end", int'(frame_count), 0);

        // 4: frame mode, one 5-beat frame
        sel = 1'b1;
        step(1);
        clear_mon();
        m_ready = 1'b1;
        send(5, 200, 4);
        wait_dlv(5, 40);
        @(negedge clk); #1;
        chk("t4_gate_latency", first_val_c - last_acc_c, 3);
        chk("t4_contiguous", last_dlv_c - first_dlv_c, 4);
        chk("t4_fc_at_last", fr_at_last, 1);
        chk("t4_fc_end", int'(frame_count), 0);
        check_seq("t4", 200, 5, 4);

        // 5: frame mode, 16 beats without tlast trigger the release
        step(1);
        clear_mon();
        send(16, 0, -1);
        wait_dlv(16, 60);
        chk("t5_force_pulses", n_force, 1);
        check_seq("t5", 0, 16, -1);
        step(1);
        clear_mon();
        send(1, 16, 0);
        wait_dlv(1, 20);
        check_seq("t5_tlast", 16, 1, 0);
        step(2);
        clear_mon();
        send(1, 17, -1);
        step(10);
        @(negedge clk); #1;
        nf = n_force;
        chk("t5_gate_closed", int'(m_valid), 0);
        chk("t5_no_dlv", n_dlv, 0);
        chk("t5_count", int'(count), 1);
        chk("t5_no_refire", nf, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
